// File: rtl/panel_lamp_scheduler.sv
// panel_lamp_scheduler
// Shares the four 16-bit front-panel lamp chains between NREQ requesters.
// Requester writes are merged into a shadow buffer under a round-robin
// arbiter. The shadow is copied to the driver-facing registers only at the
// last cycle of each driver frame, so the shift driver never sees a
// half-updated frame. Lamp-test and blank overrides are applied at that copy.

module panel_lamp_scheduler #(
  parameter int NREQ         = 3,
  parameter int FRAME_CYCLES = 34
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [2*NREQ-1:0]    req_chan,
  input  logic [16*NREQ-1:0]   req_data,
  input  logic [16*NREQ-1:0]   req_mask,
  input  logic                 lamp_test,
  input  logic                 blank,
  output logic [15:0]          data_0,
  output logic [15:0]          data_1,
  output logic [15:0]          data_2,
  output logic [15:0]          data_3,
  output logic                 frame_tick,
  output logic                 pending
);

  localparam int RRW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int FW  = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;

  // State registers and their next-state values
  logic [FW-1:0]  fcnt_q, fcnt_d;
  logic [RRW-1:0] rr_q, rr_d;
  logic [15:0]    shadow_q [4];
  logic [15:0]    shadow_d [4];
  logic [15:0]    data_q   [4];
  logic [15:0]    data_d   [4];
  logic           tick_q, tick_d;
  logic           pending_q, pending_d;

  // Arbiter results and the selected request fields
  logic           gnt_vld_s;
  logic [RRW-1:0] gnt_idx_s;
  logic [RRW:0]   cand_s;
  logic           xfer_s;
  logic           commit_s;
  logic [1:0]     sel_chan_s;
  logic [15:0]    sel_data_s;
  logic [15:0]    sel_mask_s;

  assign commit_s = (fcnt_q == FW'(FRAME_CYCLES - 1));

  // Round-robin search starting at rr; grant is suppressed while in reset
  always_comb begin
    gnt_vld_s = 1'b0;
    gnt_idx_s = '0;
    cand_s    = '0;
    req_ready = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_s = {1'b0, rr_q} + (RRW+1)'(k);
      if (cand_s >= (RRW+1)'(NREQ)) begin
        cand_s = cand_s - (RRW+1)'(NREQ);
      end else begin
        cand_s = cand_s;
      end
      if (!gnt_vld_s && req_valid[cand_s[RRW-1:0]]) begin
        gnt_vld_s = 1'b1;
        gnt_idx_s = cand_s[RRW-1:0];
      end else begin
        gnt_vld_s = gnt_vld_s;
      end
    end
    xfer_s = gnt_vld_s && !reset;
    if (xfer_s) begin
      req_ready[gnt_idx_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Pick out the granted requester's channel, data and mask
  always_comb begin
    sel_chan_s = req_chan[2*gnt_idx_s +: 2];
    sel_data_s = req_data[16*gnt_idx_s +: 16];
    sel_mask_s = req_mask[16*gnt_idx_s +: 16];
  end

  // Next-state: frame counter, rr pointer, shadow merge, commit, flags
  always_comb begin
    fcnt_d = commit_s ? '0 : fcnt_q + FW'(1);

    if (xfer_s) begin
      rr_d = (gnt_idx_s == RRW'(NREQ - 1)) ? '0 : gnt_idx_s + RRW'(1);
    end else begin
      rr_d = rr_q;
    end

    shadow_d = shadow_q;
    if (xfer_s) begin
      shadow_d[sel_chan_s] = (shadow_q[sel_chan_s] & ~sel_mask_s) |
                             (sel_data_s & sel_mask_s);
    end else begin
      shadow_d = shadow_q;
    end

    // Commit uses the shadow as it was before any same-cycle write
    data_d = data_q;
    for (int k = 0; k < 4; k++) begin
      if (commit_s) begin
        data_d[k] = blank     ? 16'h0000 :
                    lamp_test ? 16'hFFFF : shadow_q[k];
      end else begin
        data_d[k] = data_q[k];
      end
    end

    tick_d = commit_s;

    if (xfer_s) begin
      pending_d = 1'b1;
    end else if (commit_s) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      fcnt_q    <= '0;
      rr_q      <= '0;
      tick_q    <= 1'b0;
      pending_q <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        shadow_q[k] <= 16'h0000;
        data_q[k]   <= 16'h0000;
      end
    end else begin
      fcnt_q    <= fcnt_d;
      rr_q      <= rr_d;
      tick_q    <= tick_d;
      pending_q <= pending_d;
      for (int k = 0; k < 4; k++) begin
        shadow_q[k] <= shadow_d[k];
        data_q[k]   <= data_d[k];
      end
    end
  end

  assign data_0     = data_q[0];
  assign data_1     = data_q[1];
  assign data_2     = data_q[2];
  assign data_3     = data_q[3];
  assign frame_tick = tick_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_panel_lamp_scheduler.sv
// Directed testbench for panel_lamp_scheduler: table of writes with
// hand-computed committed patterns, plus sequences for arbitration order,
// commit-cycle writes and mid-frame reset.

module tb_panel_lamp_scheduler;

  localparam int NREQ = 3;
  localparam int FC   = 34;

  logic               clk = 1'b0;
  logic               reset;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [2*NREQ-1:0]  req_chan;
  logic [16*NREQ-1:0] req_data;
  logic [16*NREQ-1:0] req_mask;
  logic               lamp_test;
  logic               blank;
  logic [15:0]        data_0, data_1, data_2, data_3;
  logic               frame_tick;
  logic               pending;

  panel_lamp_scheduler #(.NREQ(NREQ), .FRAME_CYCLES(FC)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_chan(req_chan), .req_data(req_data), .req_mask(req_mask),
    .lamp_test(lamp_test), .blank(blank),
    .data_0(data_0), .data_1(data_1), .data_2(data_2), .data_3(data_3),
    .frame_tick(frame_tick), .pending(pending)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  logic [15:0] sh [4];

  typedef struct {
    int          r;
    int          chan;
    logic [15:0] data;
    logic [15:0] mask;
    logic        lt;
    logic        bl;
    logic [15:0] e0, e1, e2, e3;
  } vec_t;

  vec_t vt [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Advance until the DUT's frame counter (tracked by the bench) equals n
  task automatic wait_fcnt(input int n);
    for (int i = 0; i < FC && (cyc % FC) != n; i++) step();
  endtask

  task automatic check_data(input string name, input logic [15:0] e0, e1, e2, e3);
    check({name, "_d0"}, {16'h0, data_0}, {16'h0, e0});
    check({name, "_d1"}, {16'h0, data_1}, {16'h0, e1});
    check({name, "_d2"}, {16'h0, data_2}, {16'h0, e2});
    check({name, "_d3"}, {16'h0, data_3}, {16'h0, e3});
  endtask

  task automatic drive_req(input int r, input int c, input logic [15:0] d, input logic [15:0] m);
    req_valid[r]          = 1'b1;
    req_chan[2*r +: 2]    = 2'(c);
    req_data[16*r +: 16]  = d;
    req_mask[16*r +: 16]  = m;
  endtask

  // Single requester write; it must be granted in the same cycle
  task automatic do_write(input int r, input int c, input logic [15:0] d, input logic [15:0] m);
    req_valid = '0;
    drive_req(r, c, d, m);
    #1;
    check("ready_single", {29'h0, req_ready}, 32'(1 << r));
    step();
    sh[c] = (sh[c] & ~m) | (d & m);
    req_valid = '0;
    check("pending_set", {31'h0, pending}, 32'h1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    cyc = 0;
    for (int k = 0; k < 4; k++) sh[k] = 16'h0000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] p0, p1, p2, p3;
    logic [15:0] old_v;
    logic [2:0]  exp_ord [3];

    vt[0] = '{0, 2, 16'hA5A5, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'hA5A5, 16'h0000};
    vt[1] = '{1, 1, 16'hFF00, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 16'hFF00, 16'hA5A5, 16'h0000};
    vt[2] = '{2, 1, 16'h00FF, 16'h0F0F, 1'b0, 1'b0, 16'h0000, 16'hF00F, 16'hA5A5, 16'h0000};
    vt[3] = '{0, 0, 16'h1234, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'hF00F, 16'hA5A5, 16'h0000};
    vt[4] = '{1, 3, 16'hBEEF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    vt[5] = '{2, 0, 16'h5555, 16'h00FF, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vt[6] = '{0, 3, 16'h0F0F, 16'h00F0, 1'b0, 1'b0, 16'h0055, 16'hF00F, 16'hA5A5, 16'hBE0F};

    req_valid = '0; req_chan = '0; req_data = '0; req_mask = '0;
    lamp_test = 1'b0; blank = 1'b0; reset = 1'b1;

    // Reset state, with a request present that must not be granted
    req_valid = 3'b001;
    #1;
    check("ready_in_reset", {29'h0, req_ready}, 32'h0);
    do_reset();
    req_valid = '0;
    check_data("reset", 16'h0, 16'h0, 16'h0, 16'h0);
    check("reset_tick", {31'h0, frame_tick}, 32'h0);
    check("reset_pending", {31'h0, pending}, 32'h0);

    // Idle two frames: tick exactly at cycles 34 and 68
    for (int i = 0; i < 2*FC; i++) begin
      step();
      check("idle_tick", {31'h0, frame_tick}, {31'h0, (cyc == FC || cyc == 2*FC)});
    end
    check_data("idle", 16'h0, 16'h0, 16'h0, 16'h0);
    check("idle_pending", {31'h0, pending}, 32'h0);

    // Table of writes, each committed at the following frame boundary
    p0 = 16'h0; p1 = 16'h0; p2 = 16'h0; p3 = 16'h0;
    for (int i = 0; i < 7; i++) begin
      wait_fcnt(5);
      check_data("stable", p0, p1, p2, p3);
      do_write(vt[i].r, vt[i].chan, vt[i].data, vt[i].mask);
      lamp_test = vt[i].lt;
      blank     = vt[i].bl;
      step();
      check_data("no_early", p0, p1, p2, p3);
      wait_fcnt(0);
      check("vec_tick", {31'h0, frame_tick}, 32'h1);
      check("vec_pending_clr", {31'h0, pending}, 32'h0);
      check_data("vec", vt[i].e0, vt[i].e1, vt[i].e2, vt[i].e3);
      p0 = vt[i].e0; p1 = vt[i].e1; p2 = vt[i].e2; p3 = vt[i].e3;
    end
    check_data("model_agree", sh[0], sh[1], sh[2], sh[3]);

    // Round-robin: after a requester-2 transfer rr=0, order must be 0,1,2;
    // after a requester-0 transfer rr=1, order must be 1,2,0
    for (int pass = 0; pass < 2; pass++) begin
      wait_fcnt(3);
      do_write((pass == 0) ? 2 : 0, 0, 16'h0101, 16'h0000);
      if (pass == 0) begin
        exp_ord[0] = 3'b001; exp_ord[1] = 3'b010; exp_ord[2] = 3'b100;
      end else begin
        exp_ord[0] = 3'b010; exp_ord[1] = 3'b100; exp_ord[2] = 3'b001;
      end
      drive_req(0, 0, 16'h1000, 16'hFFFF);
      drive_req(1, 1, 16'h2000, 16'hFFFF);
      drive_req(2, 2, 16'h3000, 16'hFFFF);
      for (int g = 0; g < 3; g++) begin
        #1;
        check("rr_order", {29'h0, req_ready}, {29'h0, exp_ord[g]});
        step();
        req_valid = req_valid & ~exp_ord[g];
      end
      sh[0] = 16'h1000; sh[1] = 16'h2000; sh[2] = 16'h3000;
      wait_fcnt(0);
      check_data("rr_commit", sh[0], sh[1], sh[2], sh[3]);
    end

    // Write in the commit cycle: old value committed, new one a frame later
    wait_fcnt(FC - 1);
    old_v = sh[3];
    do_write(1, 3, 16'hC0DE, 16'hFFFF);
    check("cc_tick", {31'h0, frame_tick}, 32'h1);
    check("cc_pending_kept", {31'h0, pending}, 32'h1);
    check("cc_old", {16'h0, data_3}, {16'h0, old_v});
    wait_fcnt(FC - 1);
    check("cc_hold", {16'h0, data_3}, {16'h0, old_v});
    step();
    check("cc_new", {16'h0, data_3}, 32'h0000C0DE);
    check("cc_pending_clr", {31'h0, pending}, 32'h0);

    // Reset at fcnt=20 with a write in flight
    wait_fcnt(10);
    do_write(2, 1, 16'h7777, 16'hFFFF);
    wait_fcnt(20);
    reset = 1'b1;
    drive_req(0, 2, 16'h9999, 16'hFFFF);
    #1;
    check("rst_ready", {29'h0, req_ready}, 32'h0);
    step();
    check_data("rst_mid", 16'h0, 16'h0, 16'h0, 16'h0);
    check("rst_pending", {31'h0, pending}, 32'h0);
    check("rst_tick", {31'h0, frame_tick}, 32'h0);
    reset = 1'b0;
    req_valid = '0;
    cyc = 0;
    for (int k = 0; k < 4; k++) sh[k] = 16'h0000;
    for (int i = 0; i < FC; i++) begin
      step();
      check("rst_restart_tick", {31'h0, frame_tick}, {31'h0, (i == FC - 1)});
    end
    check_data("rst_after", 16'h0, 16'h0, 16'h0, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
